// File: rtl/stream_mux_pkg.sv
// rtl/stream_mux_pkg.sv - shared constants and types for the 4:1 stream merger
package stream_mux_pkg;

    localparam int NCH   = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } mux_state_t;

endpackage

// File: rtl/stream_mux4_1_if.sv
// rtl/stream_mux4_1_if.sv - four input channels plus one tagged output stream
interface stream_mux4_1_if #(
    parameter int WIDTH = 8
);
    import stream_mux_pkg::*;

    logic [NCH-1:0]       in_valid;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_last;
    logic [NCH-1:0]       in_ready;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_data;
    logic                 out_last;
    logic [SEL_W-1:0]     out_sel;
    logic                 out_ready;

    // The merger sits on the slave side: it consumes channel beats and sources the output.
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_sel
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_sel
    );

endinterface

// File: rtl/rr_arb4.sv
// rtl/rr_arb4.sv - combinational round-robin pick among four requests
module rr_arb4
    import stream_mux_pkg::*;
(
    input  logic [NCH-1:0]   req,
    input  logic [SEL_W-1:0] ptr,
    output logic [NCH-1:0]   gnt,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    logic [SEL_W-1:0] cand;
    logic             hit;

    assign any = |req;

    // Walk ptr+1, ptr+2, ptr+3, ptr and take the first requester; the last granted goes last.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        hit  = 1'b0;
        cand = '0;
        for (int i = 1; i <= NCH; i++) begin
            cand = ptr + SEL_W'(i);
            if (!hit && req[cand]) begin
                hit       = 1'b1;
                idx       = cand;
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux4_1.sv
// rtl/stream_mux4_1.sv - round-robin 4:1 stream merger with optional packet lock
module stream_mux4_1
    import stream_mux_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter bit LOCK_PKT = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    stream_mux4_1_if.slave bus
);

    mux_state_t       state;
    mux_state_t       state_nxt;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] owner;
    logic [SEL_W-1:0] sel;
    logic [NCH-1:0]   ready;
    logic             take;
    logic             load_ok;

    logic [NCH-1:0]   arb_gnt;
    logic [SEL_W-1:0] arb_idx;
    logic             arb_any;

    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_last_q;
    logic [SEL_W-1:0] out_sel_q;

    assign load_ok       = !out_valid_q || bus.out_ready;
    assign bus.in_ready  = ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_sel   = out_sel_q;

    rr_arb4 u_arb (
        .req (bus.in_valid),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    // Grant selection and next state; reset forces every ready low so nothing is consumed.
    always_comb begin
        state_nxt = state;
        sel       = arb_idx;
        ready     = '0;
        take      = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (load_ok && arb_any) begin
                        ready = arb_gnt;
                        take  = 1'b1;
                        if (LOCK_PKT && !bus.in_last[arb_idx]) begin
                            state_nxt = LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    sel = owner;
                    if (load_ok && bus.in_valid[owner]) begin
                        ready[owner] = 1'b1;
                        take         = 1'b1;
                        if (bus.in_last[owner]) begin
                            state_nxt = IDLE;
                        end
                    end
                end
            endcase
        end
    end

    // State, arbitration pointer, packet owner and the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= 2'b11;
            owner       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_sel_q   <= '0;
        end else begin
            state <= state_nxt;
            if (take) begin
                out_valid_q <= 1'b1;
                out_data_q  <= bus.in_data[int'(sel) * WIDTH +: WIDTH];
                out_last_q  <= bus.in_last[sel];
                out_sel_q   <= sel;
                ptr         <= sel;
                if (state == IDLE) begin
                    owner <= sel;
                end
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux4_1.sv
// tb/tb_stream_mux4_1.sv - directed self-checking bench for stream_mux4_1
module tb_stream_mux4_1;
    import stream_mux_pkg::*;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   k;
    int   exp_sel;
    int   exp_data;

    stream_mux4_1_if #(.WIDTH(8)) a_if ();
    stream_mux4_1_if #(.WIDTH(8)) b_if ();

    stream_mux4_1 #(.WIDTH(8), .LOCK_PKT(1'b1)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (a_if)
    );

    stream_mux4_1 #(.WIDTH(8), .LOCK_PKT(1'b0)) u_dut_nl (
        .clk (clk),
        .rst (rst),
        .bus (b_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic v, input logic [7:0] d,
                         input logic l, input logic [1:0] s);
        chk({tag, "_valid"}, 32'(a_if.out_valid), 32'(v));
        chk({tag, "_data"},  32'(a_if.out_data),  32'(d));
        chk({tag, "_last"},  32'(a_if.out_last),  32'(l));
        chk({tag, "_sel"},   32'(a_if.out_sel),   32'(s));
    endtask

    initial begin
        rst            = 1'b1;
        a_if.in_valid  = 4'hF;
        a_if.in_data   = 32'h44332211;
        a_if.in_last   = 4'hF;
        a_if.out_ready = 1'b1;
        b_if.in_valid  = 4'h0;
        b_if.in_data   = '0;
        b_if.in_last   = 4'h0;
        b_if.out_ready = 1'b1;

        // reset held two cycles with every channel valid
        #1;
        chk("rst_ready_early", 32'(a_if.in_ready), 32'h0);
        tick;
        tick;
        chk("rst_ready", 32'(a_if.in_ready), 32'h0);
        chk_a("rst", 1'b0, 8'h00, 1'b0, 2'd0);
        chk("rst_state", 32'(u_dut.state), 32'(IDLE));

        // single beat on ch2
        rst           = 1'b0;
        a_if.in_valid = 4'b0100;
        a_if.in_data  = {8'h00, 8'hA5, 8'h00, 8'h00};
        a_if.in_last  = 4'b0100;
        #1;
        chk("single_ready", 32'(a_if.in_ready), 32'b0100);
        tick;
        chk_a("single", 1'b1, 8'hA5, 1'b1, 2'd2);
        a_if.in_valid = 4'b0000;
        tick;
        chk("single_drain_valid", 32'(a_if.out_valid), 32'h0);

        // round robin from a fresh pointer
        rst = 1'b1;
        tick;
        rst           = 1'b0;
        a_if.in_valid = 4'hF;
        a_if.in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        a_if.in_last  = 4'hF;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("rr_ready", 32'(a_if.in_ready), 32'(1 << (i % 4)));
            tick;
            chk_a("rr", 1'b1, 8'(8'h10 + (i % 4)), 1'b1, 2'(i % 4));
        end
        a_if.in_valid = 4'b0000;
        tick;
        chk("rr_drain_valid", 32'(a_if.out_valid), 32'h0);

        // ch1 three-beat packet locks out ch0
        a_if.in_valid = 4'b0011;
        a_if.in_data  = {8'h00, 8'h00, 8'h31, 8'h20};
        a_if.in_last  = 4'b0001;
        #1;
        chk("lock_ready1", 32'(a_if.in_ready), 32'b0010);
        tick;
        chk_a("lock1", 1'b1, 8'h31, 1'b0, 2'd1);
        chk("lock1_state", 32'(u_dut.state), 32'(LOCKED));
        a_if.in_data = {8'h00, 8'h00, 8'h32, 8'h20};
        #1;
        chk("lock_ready2", 32'(a_if.in_ready), 32'b0010);
        tick;
        chk_a("lock2", 1'b1, 8'h32, 1'b0, 2'd1);
        a_if.in_data = {8'h00, 8'h00, 8'h33, 8'h20};
        a_if.in_last = 4'b0011;
        #1;
        chk("lock_ready3", 32'(a_if.in_ready), 32'b0010);
        tick;
        chk_a("lock3", 1'b1, 8'h33, 1'b1, 2'd1);
        chk("lock3_state", 32'(u_dut.state), 32'(IDLE));
        a_if.in_valid = 4'b0001;
        #1;
        chk("lock_ready4", 32'(a_if.in_ready), 32'b0001);
        tick;
        chk_a("lock4", 1'b1, 8'h20, 1'b1, 2'd0);
        a_if.in_valid = 4'b0000;
        tick;
        chk("lock_drain_valid", 32'(a_if.out_valid), 32'h0);

        // backpressure holds the register and blocks all inputs
        a_if.in_valid  = 4'b0100;
        a_if.in_data   = {8'h00, 8'h41, 8'h00, 8'h00};
        a_if.in_last   = 4'b0100;
        a_if.out_ready = 1'b0;
        #1;
        chk("bp_ready_first", 32'(a_if.in_ready), 32'b0100);
        tick;
        chk_a("bp_first", 1'b1, 8'h41, 1'b1, 2'd2);
        a_if.in_data = {8'h00, 8'h42, 8'h00, 8'h00};
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready_stall", 32'(a_if.in_ready), 32'h0);
            tick;
            chk_a("bp_hold", 1'b1, 8'h41, 1'b1, 2'd2);
        end
        a_if.out_ready = 1'b1;
        #1;
        chk("bp_ready_release", 32'(a_if.in_ready), 32'b0100);
        tick;
        chk_a("bp_next", 1'b1, 8'h42, 1'b1, 2'd2);
        a_if.in_valid = 4'b0000;
        tick;
        chk_a("bp_drain", 1'b0, 8'h42, 1'b1, 2'd2);

        // reset while locked on ch3
        a_if.in_valid = 4'b1000;
        a_if.in_data  = {8'h51, 8'h00, 8'h00, 8'h00};
        a_if.in_last  = 4'b0000;
        #1;
        chk("mid_ready1", 32'(a_if.in_ready), 32'b1000);
        tick;
        chk_a("mid1", 1'b1, 8'h51, 1'b0, 2'd3);
        chk("mid1_state", 32'(u_dut.state), 32'(LOCKED));
        a_if.in_data = {8'h52, 8'h00, 8'h00, 8'h00};
        rst          = 1'b1;
        #1;
        chk("mid_ready_rst", 32'(a_if.in_ready), 32'h0);
        tick;
        chk_a("mid_rst", 1'b0, 8'h00, 1'b0, 2'd0);
        chk("mid_rst_state", 32'(u_dut.state), 32'(IDLE));
        rst           = 1'b0;
        a_if.in_valid = 4'b1001;
        a_if.in_data  = {8'h51, 8'h00, 8'h00, 8'h60};
        a_if.in_last  = 4'b0001;
        #1;
        chk("mid_ready_after", 32'(a_if.in_ready), 32'b0001);
        tick;
        chk_a("mid_after", 1'b1, 8'h60, 1'b1, 2'd0);
        a_if.in_valid = 4'b0000;
        tick;

        // no-lock instance: park the pointer on ch0 first
        b_if.in_valid = 4'b0001;
        b_if.in_data  = {8'h00, 8'h00, 8'h00, 8'h70};
        b_if.in_last  = 4'b0001;
        #1;
        chk("nl_ready_park", 32'(b_if.in_ready), 32'b0001);
        tick;
        chk("nl_park_sel", 32'(b_if.out_sel), 32'd0);
        chk("nl_park_data", 32'(b_if.out_data), 32'h70);

        // ch1 packet interleaves with ch0 every beat
        k             = 1;
        b_if.in_valid = 4'b0011;
        b_if.in_data  = {8'h00, 8'h00, 8'h31, 8'h20};
        b_if.in_last  = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            exp_sel  = (i % 2 == 0) ? 1 : 0;
            exp_data = (exp_sel == 1) ? (8'h30 + k) : 8'h20;
            #1;
            chk("nl_ready", 32'(b_if.in_ready), 32'(1 << exp_sel));
            tick;
            chk("nl_sel", 32'(b_if.out_sel), 32'(exp_sel));
            chk("nl_data", 32'(b_if.out_data), 32'(exp_data));
            chk("nl_last", 32'(b_if.out_last), (exp_sel == 1) ? 32'(k == 3) : 32'd1);
            if (exp_sel == 1) begin
                k++;
                b_if.in_data[15:8] = 8'(8'h30 + k);
                b_if.in_last[1]    = (k == 3);
            end
        end
        b_if.in_valid = 4'b0000;
        tick;
        chk("nl_drain_valid", 32'(b_if.out_valid), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
